// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle RV32I instruction sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, drives memory handshakes and datapath enables.
`default_nettype none

module multicycle_seq_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [6:0]       opcode,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             alu_src,
  output logic [2:0]       alu_op,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             trap,
  output logic [1:0]       trap_cause
);

  localparam int TMO_W = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  // Instruction class doubles as the ALU class code driven on alu_op.
  localparam logic [2:0] CLS_R    = 3'b000;
  localparam logic [2:0] CLS_I    = 3'b001;
  localparam logic [2:0] CLS_S    = 3'b010;
  localparam logic [2:0] CLS_B    = 3'b011;
  localparam logic [2:0] CLS_U    = 3'b100;
  localparam logic [2:0] CLS_J    = 3'b101;
  localparam logic [2:0] CLS_LOAD = 3'b110;
  localparam logic [2:0] CLS_JALR = 3'b111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] CAUSE_NONE    = 2'd0;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
  localparam logic [1:0] CAUSE_IMEM    = 2'd2;
  localparam logic [1:0] CAUSE_DMEM    = 2'd3;

  localparam logic [1:0] PCSEL_SEQ  = 2'd0;
  localparam logic [1:0] PCSEL_REL  = 2'd1;
  localparam logic [1:0] PCSEL_JALR = 2'd2;

  state_t           state_reg, state_next;
  logic [2:0]       class_reg, class_next;
  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [1:0]       cause_reg, cause_next;
  logic [CNT_W-1:0] instret_reg;

  logic             dec_legal;
  logic [2:0]       dec_class;
  logic             tmo_hit;
  logic             is_mem_class;

  always_comb begin
    dec_legal = 1'b1;
    dec_class = CLS_R;
    case (opcode)
      OP_R:      dec_class = CLS_R;
      OP_I:      dec_class = CLS_I;
      OP_LOAD:   dec_class = CLS_LOAD;
      OP_STORE:  dec_class = CLS_S;
      OP_BRANCH: dec_class = CLS_B;
      OP_AUIPC:  dec_class = CLS_U;
      OP_JAL:    dec_class = CLS_J;
      OP_JALR:   dec_class = CLS_JALR;
      default:   dec_legal = 1'b0;
    endcase
  end

  assign tmo_hit      = (tmo_cnt_reg == TMO_W'(MEM_TIMEOUT));
  assign is_mem_class = (class_reg == CLS_LOAD) || (class_reg == CLS_S);

  // State and bookkeeping registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      class_reg   <= CLS_R;
      tmo_cnt_reg <= '0;
      cause_reg   <= CAUSE_NONE;
      instret_reg <= '0;
    end else begin
      state_reg   <= state_next;
      class_reg   <= class_next;
      tmo_cnt_reg <= tmo_cnt_next;
      cause_reg   <= cause_next;
      if (retire) begin
        instret_reg <= instret_reg + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    class_next = class_reg;
    cause_next = cause_reg;
    case (state_reg)
      S_IDLE: begin
        if (en) state_next = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ready) begin
          state_next = S_DECODE;
        end else if (tmo_hit) begin
          state_next = S_TRAP;
          cause_next = CAUSE_IMEM;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          class_next = dec_class;
          state_next = S_EXEC;
        end else begin
          state_next = S_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (class_reg == CLS_B)  state_next = S_FETCH;
        else if (is_mem_class)   state_next = S_MEM;
        else                     state_next = S_WB;
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_next = (class_reg == CLS_LOAD) ? S_WB : S_FETCH;
        end else if (tmo_hit) begin
          state_next = S_TRAP;
          cause_next = CAUSE_DMEM;
        end
      end
      S_WB:    state_next = S_FETCH;
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_IDLE;
    endcase

    // Any state change restarts the wait counter, so it is zero on FETCH/MEM entry.
    if (state_next != state_reg) begin
      tmo_cnt_next = '0;
    end else if (state_reg == S_FETCH || state_reg == S_MEM) begin
      tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
    end else begin
      tmo_cnt_next = tmo_cnt_reg;
    end
  end

  always_comb begin
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = PCSEL_SEQ;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_src    = 1'b0;
    alu_op     = CLS_R;
    retire     = 1'b0;

    if (state_reg == S_EXEC || state_reg == S_MEM || state_reg == S_WB) begin
      alu_op  = class_reg;
      alu_src = (class_reg != CLS_R) && (class_reg != CLS_B);
    end

    case (state_reg)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ready;
      end
      S_EXEC: begin
        if (class_reg == CLS_B) begin
          pc_write = 1'b1;
          pc_sel   = branch_taken ? PCSEL_REL : PCSEL_SEQ;
          retire   = 1'b1;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (class_reg == CLS_S);
        if (dmem_ready && class_reg == CLS_S) begin
          pc_write = 1'b1;
          retire   = 1'b1;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        pc_write   = 1'b1;
        retire     = 1'b1;
        mem_to_reg = (class_reg == CLS_LOAD);
        if (class_reg == CLS_J)         pc_sel = PCSEL_REL;
        else if (class_reg == CLS_JALR) pc_sel = PCSEL_JALR;
      end
      default: ;
    endcase
  end

  assign instret    = instret_reg;
  assign trap       = (state_reg == S_TRAP);
  assign trap_cause = cause_reg;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_seq_ctrl.sv
// Scoreboard bench for multicycle_seq_ctrl: a memory responder plays out an
// instruction program, a model predicts each retirement, and a monitor checks.
module tb_multicycle_seq_ctrl;

  localparam int TMO = 4;
  localparam int CW  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic [6:0]    opcode;
  logic          branch_taken;
  logic          imem_ready;
  logic          dmem_ready;
  logic          imem_req, dmem_req, dmem_we, ir_write, pc_write;
  logic [1:0]    pc_sel;
  logic          reg_write, mem_to_reg, alu_src;
  logic [2:0]    alu_op;
  logic          retire;
  logic [CW-1:0] instret;
  logic          trap;
  logic [1:0]    trap_cause;
  logic [CW+16:0] all_outs;

  always #5 clk = ~clk;

  multicycle_seq_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_write(ir_write), .pc_write(pc_write),
    .pc_sel(pc_sel), .reg_write(reg_write), .mem_to_reg(mem_to_reg), .alu_src(alu_src),
    .alu_op(alu_op), .retire(retire), .instret(instret), .trap(trap), .trap_cause(trap_cause)
  );

  assign all_outs = {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_sel, reg_write,
                     mem_to_reg, alu_src, alu_op, retire, instret, trap, trap_cause};

  typedef struct {
    logic [6:0] op;
    logic       taken;
    int         iw;
    int         dw;
  } instr_t;

  typedef struct {
    int alu_op; int alu_src; int pc_sel; int reg_write; int mem_to_reg;
    int lat; int ireq; int dreq; int dwe;
  } exp_t;

  instr_t prog[$];
  exp_t   sb[$];
  int     trap_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     trap_seen = 0;

  function automatic void check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Opcode -> ALU class code, -1 for anything not in the legal set.
  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'b0110011: return 0;
      7'b0010011: return 1;
      7'b0100011: return 2;
      7'b1100011: return 3;
      7'b0010111: return 4;
      7'b1101111: return 5;
      7'b0000011: return 6;
      7'b1100111: return 7;
      default:    return -1;
    endcase
  endfunction

  task automatic build_expectations();
    sb.delete();
    trap_q.delete();
    for (int i = 0; i < prog.size(); i++) begin
      int c;
      bit mem;
      exp_t e;
      c   = cls_of(prog[i].op);
      mem = (c == 2) || (c == 6);
      if (prog[i].iw > TMO) begin trap_q.push_back(2); break; end
      if (c < 0)            begin trap_q.push_back(1); break; end
      if (mem && prog[i].dw > TMO) begin trap_q.push_back(3); break; end
      e.alu_op     = c;
      e.alu_src    = (c != 0 && c != 3) ? 1 : 0;
      e.pc_sel     = (c == 3) ? int'(prog[i].taken) : (c == 5) ? 1 : (c == 7) ? 2 : 0;
      e.reg_write  = (c != 3 && c != 2) ? 1 : 0;
      e.mem_to_reg = (c == 6) ? 1 : 0;
      e.lat        = ((c == 3) ? 3 : (c == 6) ? 5 : 4) + prog[i].iw + (mem ? prog[i].dw : 0);
      e.ireq       = prog[i].iw + 1;
      e.dreq       = mem ? prog[i].dw + 1 : 0;
      e.dwe        = (c == 2) ? prog[i].dw + 1 : 0;
      sb.push_back(e);
    end
  endtask

  // Memory responder: serves fetches from prog with the scheduled wait states.
  int fetch_idx = 0;
  int iw_left   = -1;
  int dw_left   = 0;
  initial begin
    imem_ready = 1'b0; dmem_ready = 1'b0; opcode = '0; branch_taken = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        imem_ready = 1'b0; dmem_ready = 1'b0; fetch_idx = 0; iw_left = -1; dw_left = 0;
      end else begin
        if (imem_req && fetch_idx < prog.size()) begin
          if (iw_left < 0) iw_left = prog[fetch_idx].iw;
          if (iw_left > 0) begin
            imem_ready = 1'b0;
            opcode     = 7'($urandom);
            iw_left--;
          end else begin
            imem_ready   = 1'b1;
            opcode       = prog[fetch_idx].op;
            branch_taken = prog[fetch_idx].taken;
            dw_left      = prog[fetch_idx].dw;
            fetch_idx++;
            iw_left      = -1;
          end
        end else begin
          imem_ready = 1'b0;
        end
        if (dmem_req) begin
          if (dw_left > 0) begin dmem_ready = 1'b0; dw_left--; end
          else dmem_ready = 1'b1;
        end else begin
          dmem_ready = 1'(($urandom & 1));
        end
      end
    end
  end

  // Monitor: measures each instruction and compares at its retire pulse.
  initial begin
    bit      in_flight = 0;
    int      lat = 0, ireq = 0, dreq = 0, dwe = 0, cause_seen = 0;
    logic [CW-1:0] model_cnt = '0;
    exp_t    e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        in_flight = 0; trap_seen = 0; model_cnt = '0;
      end else if (trap_seen) begin
        check("trap_held", trap, 1);
        check("trap_quiet", {imem_req, dmem_req, ir_write, pc_write, reg_write, retire}, 0);
        check("trap_cause_stable", trap_cause, cause_seen);
      end else if (trap) begin
        trap_seen  = 1;
        cause_seen = trap_cause;
        if (trap_q.size() == 0) check("trap_expected", trap_q.size(), 1);
        else check("trap_cause", trap_cause, trap_q.pop_front());
        check("pending_at_trap", sb.size(), 0);
        check("trap_instret", instret, model_cnt);
      end else begin
        if (imem_req && !in_flight) begin
          in_flight = 1; lat = 0; ireq = 0; dreq = 0; dwe = 0;
        end
        if (in_flight) begin
          lat++;
          ireq += int'(imem_req);
          dreq += int'(dmem_req);
          dwe  += int'(dmem_req && dmem_we);
        end
        check("pc_write_only_at_retire", pc_write, retire);
        check("stray_reg_write", reg_write & ~retire, 0);
        if (retire) begin
          if (sb.size() == 0) begin
            check("retire_expected", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            check("alu_op", alu_op, e.alu_op);
            check("alu_src", alu_src, e.alu_src);
            check("pc_sel", pc_sel, e.pc_sel);
            check("reg_write", reg_write, e.reg_write);
            check("mem_to_reg", mem_to_reg, e.mem_to_reg);
            check("latency", lat, e.lat);
            check("imem_req_cycles", ireq, e.ireq);
            check("dmem_req_cycles", dreq, e.dreq);
            check("dmem_we_cycles", dwe, e.dwe);
          end
          check("instret", instret, model_cnt);
          model_cnt = model_cnt + 1'b1;
          in_flight = 0;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #3;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    step(2);
  endtask

  task automatic run_prog(input int hold);
    int budget;
    build_expectations();
    rst    = 1'b0;
    en     = 1'b1;
    budget = 0;
    while (!trap_seen && budget < 3000) begin
      step(1);
      en = 1'(($urandom & 1));
      budget++;
    end
    check("program_terminates", trap_seen, 1);
    en = 1'b1;
    step(hold);
    check("scoreboard_drained", sb.size(), 0);
    check("trap_queue_drained", trap_q.size(), 0);
    do_reset();
  endtask

  task automatic random_prog(input int n);
    logic [6:0] legal[8];
    int sel;
    instr_t t;
    legal = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
              7'b1100011, 7'b0010111, 7'b1101111, 7'b1100111};
    prog.delete();
    for (int i = 0; i < n; i++) begin
      t.op    = legal[$urandom_range(0, 7)];
      t.taken = 1'(($urandom & 1));
      t.iw    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMO) : 0;
      t.dw    = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMO) : 0;
      prog.push_back(t);
    end
    sel = $urandom_range(0, 2);
    t.taken = 1'b0; t.iw = 0; t.dw = 0;
    if (sel == 0) begin
      t.op = 7'($urandom);
      while (cls_of(t.op) >= 0) t.op = 7'($urandom);
    end else if (sel == 1) begin
      t.op = legal[$urandom_range(0, 7)];
      t.iw = TMO + 1 + $urandom_range(0, 3);
    end else begin
      t.op = ($urandom & 1) ? 7'b0000011 : 7'b0100011;
      t.dw = TMO + 1 + $urandom_range(0, 3);
    end
    prog.push_back(t);
  endtask

  initial begin
    int budget;
    do_reset();
    check("reset_outputs", all_outs, 0);

    // Directed mix ending on an illegal opcode, then held in TRAP with en=1.
    prog = '{'{7'b0110011, 1'b0, 0, 0}, '{7'b0000011, 1'b0, 0, 3},
             '{7'b1100011, 1'b1, 0, 0}, '{7'b1100011, 1'b0, 0, 0},
             '{7'b1101111, 1'b0, 0, 0}, '{7'b1100111, 1'b0, 1, 0},
             '{7'b0100011, 1'b0, 0, 0}, '{7'b0010111, 1'b0, 0, 0},
             '{7'b0010011, 1'b0, 0, 0}, '{7'b1111111, 1'b0, 0, 0}};
    run_prog(100);

    // Ready arriving exactly at the timeout boundary wins; one cycle later traps.
    prog = '{'{7'b0110011, 1'b0, TMO, 0}, '{7'b0100011, 1'b0, 0, TMO},
             '{7'b0110011, 1'b0, TMO + 1, 0}};
    run_prog(10);

    prog = '{'{7'b0000011, 1'b0, 0, TMO + 1}};
    run_prog(10);

    for (int r = 0; r < 3; r++) begin
      random_prog(40);
      run_prog(20);
    end

    // Asynchronous reset in the middle of a LOAD's MEM phase.
    prog = '{'{7'b0000011, 1'b0, 0, 3}};
    sb.delete();
    trap_q.delete();
    rst    = 1'b0;
    en     = 1'b1;
    budget = 0;
    while (!dmem_req && budget < 50) begin
      step(1);
      budget++;
    end
    check("reached_mem", dmem_req, 1);
    step(1);
    rst = 1'b1;
    #1;
    check("async_reset_outputs", all_outs, 0);
    step(2);
    rst = 1'b0;
    en  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("idle_held", all_outs, 0);
    end
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
